game_master: RTL and testbench

- Sequencer that drives the control side of the multi-mode counter: INIT, load and CONTROL.
- Consumes the counter's event side (WINNER, LOSER, GAMEOVER, WHO).
- Seeds the counter, plays one game with a selectable CONTROL strategy, latches the outcome, and keeps per-game event tallies and cumulative win/loss totals.
- Sits beside the counter in the top level, in place of bench-driven INIT/CONTROL stimulus.

---
 rtl/game_master_if.sv | 23 ++
 rtl/game_master.sv | 175 +++++++++++++++++
 tb/tb_game_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_master_if.sv
// Control/event link between game_master and the multi-mode counter.
// INIT is a one-cycle preload strobe qualifying load; CONTROL is level-valid
// whenever the master is busy. WINNER/LOSER are one-cycle pulses, and
// GAMEOVER qualifies WHO. There is no back-pressure in either direction.
interface game_master_if;
   logic       INIT;
   logic [3:0] load;
   logic [1:0] CONTROL;
   logic       WINNER;
   logic       LOSER;
   logic       GAMEOVER;
   logic [1:0] WHO;

   modport master (
      output INIT, load, CONTROL,
      input  WINNER, LOSER, GAMEOVER, WHO
   );

   modport slave (
      input  INIT, load, CONTROL,
      output WINNER, LOSER, GAMEOVER, WHO
   );
endinterface

// File: rtl/game_master.sv
// Game sequencer for the multi-mode counter: seeds it, plays one game with a
// chosen CONTROL strategy, latches the outcome and keeps tallies and totals.
module game_master #(
   parameter int PHASE_LEN  = 8,
   parameter int MAX_CYCLES = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [1:0]        MODE_SEL,
   input  logic [3:0]        SEED,
   game_master_if.master     cnt,
   output logic              BUSY,
   output logic              DONE,
   output logic [1:0]        RESULT,
   output logic [3:0]        WIN_TALLY,
   output logic [3:0]        LOSE_TALLY,
   output logic [7:0]        GAMES_WON,
   output logic [7:0]        GAMES_LOST,
   output logic [1:0]        STATE_DBG
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_PLAY   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [15:0] LAST_CYCLE = 16'(MAX_CYCLES - 1);
   localparam logic [7:0]  LAST_PHASE = 8'(PHASE_LEN - 1);

   state_t      state_q, state_d;
   logic [1:0]  mode_q, mode_d;
   logic [3:0]  seed_q, seed_d;
   logic [15:0] cycle_q, cycle_d;
   logic [7:0]  phase_cnt_q, phase_cnt_d;
   logic        phase_q, phase_d;
   logic [1:0]  result_q, result_d;
   logic [3:0]  win_q, win_d;
   logic [3:0]  lose_q, lose_d;
   logic [7:0]  won_q, won_d;
   logic [7:0]  lost_q, lost_d;

   logic        init_c;
   logic        busy_c;
   logic        done_c;
   logic [1:0]  control_c;

   // Alternating strategy starts in phase 0, which drives +2 (CONTROL=1).
   function automatic logic [1:0] mode_ctrl(input logic [1:0] m, input logic ph);
      case (m)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         2'd2:    return ph ? 2'd0 : 2'd1;
         default: return 2'd2;
      endcase
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         mode_q      <= 2'd0;
         seed_q      <= 4'd0;
         cycle_q     <= 16'd0;
         phase_cnt_q <= 8'd0;
         phase_q     <= 1'b0;
         result_q    <= 2'd0;
         win_q       <= 4'd0;
         lose_q      <= 4'd0;
         won_q       <= 8'd0;
         lost_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         seed_q      <= seed_d;
         cycle_q     <= cycle_d;
         phase_cnt_q <= phase_cnt_d;
         phase_q     <= phase_d;
         result_q    <= result_d;
         win_q       <= win_d;
         lose_q      <= lose_d;
         won_q       <= won_d;
         lost_q      <= lost_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      seed_d      = seed_q;
      cycle_d     = cycle_q;
      phase_cnt_d = phase_cnt_q;
      phase_d     = phase_q;
      result_d    = result_q;
      win_d       = win_q;
      lose_d      = lose_q;
      won_d       = won_q;
      lost_d      = lost_q;
      init_c      = 1'b0;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      control_c   = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               mode_d  = MODE_SEL;
               seed_d  = SEED;
               win_d   = 4'd0;
               lose_d  = 4'd0;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            init_c      = 1'b1;
            busy_c      = 1'b1;
            control_c   = mode_ctrl(mode_q, 1'b0);
            cycle_d     = 16'd0;
            phase_cnt_d = 8'd0;
            phase_d     = 1'b0;
            state_d     = S_PLAY;
         end

         S_PLAY: begin
            busy_c    = 1'b1;
            control_c = mode_ctrl(mode_q, phase_q);
            cycle_d   = cycle_q + 16'd1;
            if (phase_cnt_q == LAST_PHASE) begin
               phase_cnt_d = 8'd0;
               phase_d     = ~phase_q;
            end else begin
               phase_cnt_d = phase_cnt_q + 8'd1;
            end
            if (cnt.WINNER && (win_q != 4'hF))
               win_d = win_q + 4'd1;
            if (cnt.LOSER && (lose_q != 4'hF))
               lose_d = lose_q + 4'd1;
            // GAMEOVER takes priority over a timeout landing on the same edge.
            if (cnt.GAMEOVER) begin
               result_d = cnt.WHO;
               state_d  = S_FINISH;
            end else if (cycle_q == LAST_CYCLE) begin
               result_d = 2'b11;
               state_d  = S_FINISH;
            end
         end

         S_FINISH: begin
            done_c = 1'b1;
            if ((result_q == 2'b10) && (won_q != 8'hFF))
               won_d = won_q + 8'd1;
            if ((result_q == 2'b01) && (lost_q != 8'hFF))
               lost_d = lost_q + 8'd1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign cnt.INIT    = init_c;
   assign cnt.load    = seed_q;
   assign cnt.CONTROL = control_c;
   assign BUSY        = busy_c;
   assign DONE        = done_c;
   assign RESULT      = result_q;
   assign WIN_TALLY   = win_q;
   assign LOSE_TALLY  = lose_q;
   assign GAMES_WON   = won_q;
   assign GAMES_LOST  = lost_q;
   assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_game_master.sv
// Directed bench for game_master: a small counter model for the win game,
// bench-driven events elsewhere, hand-computed expectations throughout.
module tb_game_master;

   localparam int TB_PHASE = 4;
   localparam int TB_MAX   = 24;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [1:0] MODE_SEL;
   logic [3:0] SEED;
   logic       BUSY;
   logic       DONE;
   logic [1:0] RESULT;
   logic [3:0] WIN_TALLY;
   logic [3:0] LOSE_TALLY;
   logic [7:0] GAMES_WON;
   logic [7:0] GAMES_LOST;
   logic [1:0] STATE_DBG;

   int n_vec  = 0;
   int n_miss = 0;

   logic [1:0] exp_q[$];

   logic       cnt_en;
   logic [3:0] cnt_m;
   logic       win_model;
   logic       win_drv;
   logic       los_drv;
   logic       go_drv;
   logic [1:0] who_drv;

   game_master_if bus();

   game_master #(.PHASE_LEN(TB_PHASE), .MAX_CYCLES(TB_MAX)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .MODE_SEL   (MODE_SEL),
      .SEED       (SEED),
      .cnt        (bus),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .RESULT     (RESULT),
      .WIN_TALLY  (WIN_TALLY),
      .LOSE_TALLY (LOSE_TALLY),
      .GAMES_WON  (GAMES_WON),
      .GAMES_LOST (GAMES_LOST),
      .STATE_DBG  (STATE_DBG)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- counter model ----------------
   always @(posedge CLK) begin
      if (cnt_en) begin
         if (bus.INIT)
            cnt_m <= bus.load;
         else
            case (bus.CONTROL)
               2'd0:    cnt_m <= cnt_m + 4'd1;
               2'd1:    cnt_m <= cnt_m + 4'd2;
               2'd2:    cnt_m <= cnt_m - 4'd1;
               default: cnt_m <= cnt_m - 4'd2;
            endcase
      end
   end

   assign win_model = cnt_en && !bus.INIT &&
                      (((bus.CONTROL == 2'd0) && (cnt_m == 4'd15)) ||
                       ((bus.CONTROL == 2'd1) && (cnt_m >= 4'd14)));

   assign bus.WINNER   = cnt_en ? win_model : win_drv;
   assign bus.LOSER    = los_drv;
   assign bus.GAMEOVER = go_drv;
   assign bus.WHO      = who_drv;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_init"},   32'(bus.INIT), 0);
      check({tag, "_load"},   32'(bus.load), 0);
      check({tag, "_ctrl"},   32'(bus.CONTROL), 0);
      check({tag, "_busy"},   32'(BUSY), 0);
      check({tag, "_done"},   32'(DONE), 0);
      check({tag, "_result"}, 32'(RESULT), 0);
      check({tag, "_wint"},   32'(WIN_TALLY), 0);
      check({tag, "_loset"},  32'(LOSE_TALLY), 0);
      check({tag, "_won"},    32'(GAMES_WON), 0);
      check({tag, "_lost"},   32'(GAMES_LOST), 0);
      check({tag, "_state"},  32'(STATE_DBG), 0);
   endtask

   // ---------------- driver ----------------
   // Called at a negedge in IDLE; returns at the negedge of the LOAD cycle.
   task automatic start_game(input logic [1:0] m, input logic [3:0] s);
      START    = 1'b1;
      MODE_SEL = m;
      SEED     = s;
      @(negedge CLK);
      START    = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         wins_seen;
      int         first_win;
      int         play;
      logic       done_seen;
      logic [7:0] lpat;

      RST = 1'b1; START = 1'b0; MODE_SEL = 2'd0; SEED = 4'd0;
      cnt_en = 1'b0; cnt_m = 4'd0; win_drv = 1'b0; los_drv = 1'b0;
      go_drv = 1'b0; who_drv = 2'b00;
      #3;
      check_zero("reset");
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // Win game against the counter model: SEED=13, +2 each cycle.
      cnt_en = 1'b1;
      start_game(2'd1, 4'd13);
      check("g1_load_init", 32'(bus.INIT), 1);
      check("g1_load_val",  32'(bus.load), 13);
      check("g1_load_ctrl", 32'(bus.CONTROL), 1);
      check("g1_load_busy", 32'(BUSY), 1);
      @(negedge CLK);
      check("g1_init_once", 32'(bus.INIT), 0);
      check("g1_load_hold", 32'(bus.load), 13);
      wins_seen = 0; first_win = 0; done_seen = 1'b0;
      for (int k = 1; k <= 30 && !done_seen; k++) begin
         if (DONE) begin
            done_seen = 1'b1;
         end else begin
            check("g1_ctrl", 32'(bus.CONTROL), 1);
            if (bus.WINNER) begin
               wins_seen++;
               if (first_win == 0) first_win = k;
               if (wins_seen == 2) begin
                  go_drv  = 1'b1;
                  who_drv = 2'b10;
               end
            end
            @(negedge CLK);
            go_drv = 1'b0;
         end
      end
      check("g1_done_seen",  32'(done_seen), 1);
      check("g1_first_win",  32'(first_win), 2);
      check("g1_wins_model", 32'(wins_seen), 2);
      check("g1_result",     32'(RESULT), 2);
      check("g1_wint",       32'(WIN_TALLY), 2);
      check("g1_fin_busy",   32'(BUSY), 0);
      check("g1_fin_ctrl",   32'(bus.CONTROL), 0);
      cnt_en = 1'b0;
      @(negedge CLK);
      check("g1_done_pulse", 32'(DONE), 0);
      check("g1_won",        32'(GAMES_WON), 1);
      check("g1_idle",       32'(STATE_DBG), 0);

      // Events in IDLE are ignored.
      win_drv = 1'b1; los_drv = 1'b1; go_drv = 1'b1; who_drv = 2'b01;
      @(negedge CLK);
      win_drv = 1'b0; los_drv = 1'b0; go_drv = 1'b0;
      @(negedge CLK);
      check("idle_wint",   32'(WIN_TALLY), 2);
      check("idle_loset",  32'(LOSE_TALLY), 0);
      check("idle_result", 32'(RESULT), 2);
      check("idle_state",  32'(STATE_DBG), 0);
      check("idle_lost",   32'(GAMES_LOST), 0);

      // Alternating strategy, no GAMEOVER: runs to timeout.
      for (int i = 0; i < TB_MAX; i++)
         exp_q.push_back(((i / TB_PHASE) % 2 == 0) ? 2'd1 : 2'd0);
      start_game(2'd2, 4'd7);
      check("g2_load_ctrl", 32'(bus.CONTROL), 1);
      check("g2_wint_clr",  32'(WIN_TALLY), 0);
      @(negedge CLK);
      play = 0;
      for (int k = 0; k < 40 && !DONE; k++) begin
         play++;
         if (exp_q.size() > 0)
            check("g2_ctrl", 32'(bus.CONTROL), 32'(exp_q.pop_front()));
         else
            check("g2_extra_play", 32'(play), TB_MAX);
         @(negedge CLK);
      end
      check("g2_done",       32'(DONE), 1);
      check("g2_play_len",   32'(play), TB_MAX);
      check("g2_result",     32'(RESULT), 3);
      @(negedge CLK);
      check("g2_won_same",   32'(GAMES_WON), 1);
      check("g2_lost_same",  32'(GAMES_LOST), 0);

      // Reset three cycles after START aborts the game and clears totals.
      start_game(2'd1, 4'd5);
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1 check_zero("midrst");
      @(negedge CLK);
      check("midrst_done_hold", 32'(DONE), 0);
      RST = 1'b0;
      @(negedge CLK);
      check("midrst_done",  32'(DONE), 0);
      check("midrst_state", 32'(STATE_DBG), 0);
      check("midrst_won",   32'(GAMES_WON), 0);

      // Loser game, mode 3.
      lpat = 8'b0110_1101;
      start_game(2'd3, 4'd1);
      check("g3_load_ctrl", 32'(bus.CONTROL), 2);
      check("g3_load_val",  32'(bus.load), 1);
      @(negedge CLK);
      for (int k = 0; k < 8; k++) begin
         check("g3_ctrl", 32'(bus.CONTROL), 2);
         los_drv = lpat[k];
         @(negedge CLK);
      end
      los_drv = 1'b0; go_drv = 1'b1; who_drv = 2'b01;
      @(negedge CLK);
      go_drv = 1'b0;
      check("g3_done",   32'(DONE), 1);
      check("g3_result", 32'(RESULT), 1);
      check("g3_loset",  32'(LOSE_TALLY), 5);
      check("g3_wint",   32'(WIN_TALLY), 0);
      @(negedge CLK);
      check("g3_lost",   32'(GAMES_LOST), 1);
      check("g3_won",    32'(GAMES_WON), 0);

      // GAMEOVER with WHO=00 leaves the totals alone.
      start_game(2'd0, 4'd3);
      check("g4_load_ctrl", 32'(bus.CONTROL), 0);
      @(negedge CLK);
      go_drv = 1'b1; who_drv = 2'b00;
      @(negedge CLK);
      go_drv = 1'b0;
      check("g4_done",   32'(DONE), 1);
      check("g4_result", 32'(RESULT), 0);
      @(negedge CLK);
      check("g4_won",    32'(GAMES_WON), 0);
      check("g4_lost",   32'(GAMES_LOST), 1);

      // Saturation, START during PLAY, GAMEOVER on the timeout edge.
      start_game(2'd0, 4'd0);
      @(negedge CLK);
      for (int k = 1; k <= TB_MAX; k++) begin
         if (k == 6) begin
            check("g5_start_ign_init",  32'(bus.INIT), 0);
            check("g5_start_ign_state", 32'(STATE_DBG), 2);
            check("g5_start_ign_ctrl",  32'(bus.CONTROL), 0);
         end
         if (k == TB_MAX)
            check("g5_no_early_done", 32'(DONE), 0);
         win_drv  = (k <= 20);
         START    = (k == 5);
         MODE_SEL = 2'd3;
         go_drv   = (k == TB_MAX);
         who_drv  = 2'b10;
         @(negedge CLK);
      end
      win_drv = 1'b0; go_drv = 1'b0; START = 1'b0;
      check("g5_done",   32'(DONE), 1);
      check("g5_result", 32'(RESULT), 2);
      check("g5_wint",   32'(WIN_TALLY), 15);
      check("g5_loset",  32'(LOSE_TALLY), 0);
      @(negedge CLK);
      check("g5_won",        32'(GAMES_WON), 1);
      check("g5_lost",       32'(GAMES_LOST), 1);
      check("g5_state",      32'(STATE_DBG), 0);
      check("g5_wint_hold",  32'(WIN_TALLY), 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
